// File: rtl/fsm_vector_sequencer_pkg.sv
// Shared definitions for the vector sequencer.
// Contents:
//   seq_state_t         controller state encoding (IDLE=0, LOAD=1, RUN=2, DONE=3)
//   VEC_RST/VEC_IN/VEC_EXP  bit positions of the fields inside one 3-bit vector word
package fsm_vector_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  localparam int VEC_W   = 3;
  localparam int VEC_RST = 2;
  localparam int VEC_IN  = 1;
  localparam int VEC_EXP = 0;

endpackage

// File: rtl/fsm_vector_sequencer.sv
// Replays a table of {reset, in, expected} vectors from a combinational ROM into a
// 1-bit serial FSM and checks the FSM's Mealy output once per applied vector.
// Ports:
//   clk            clock, all state on posedge
//   reset          synchronous active-low reset
//   start          begin a run (only honoured in IDLE)
//   stop           abort the current run (honoured in LOAD/RUN)
//   vec_addr       ROM address
//   vec_data       ROM word {rst,in,exp} at vec_addr
//   dut_reset      registered active-high reset to the FSM under test
//   dut_in         registered serial input to the FSM under test
//   dut_out        FSM output for the vector currently on its pins
//   busy           high in LOAD and RUN
//   done           one-cycle pulse when a run completes or is aborted
//   aborted        run ended by stop; held until the next start
//   mismatch       combinational compare result for the current RUN cycle
//   error_count    mismatches in this run
//   err_seen       at least one mismatch in this run
//   first_err_addr vector index of the first mismatch
module fsm_vector_sequencer
  import fsm_vector_sequencer_pkg::*;
#(
  parameter int DEPTH = 13,
  parameter int AW    = $clog2(DEPTH) + 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic [AW-1:0]     vec_addr,
  input  logic [VEC_W-1:0]  vec_data,
  output logic              dut_reset,
  output logic              dut_in,
  input  logic              dut_out,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              mismatch,
  output logic [CW-1:0]     error_count,
  output logic              err_seen,
  output logic [AW-1:0]     first_err_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  seq_state_t    state;
  seq_state_t    state_next;
  logic [AW-1:0] idx;
  logic          expected;
  logic          is_last;
  logic          addr_at_end;

  assign is_last     = (idx == LAST);
  // The address stops at the last table entry so it never points past the ROM.
  assign addr_at_end = (vec_addr == LAST);

  assign busy  = (state == ST_LOAD) || (state == ST_RUN);
  assign done  = (state == ST_DONE);
  // Case inequality so that an X/Z output from the FSM is reported as a mismatch.
  assign mismatch = (state == ST_RUN) && (dut_out !== expected);

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_LOAD;
      ST_LOAD: state_next = stop ? ST_DONE : ST_RUN;
      ST_RUN:  if (stop || is_last) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: the FSM pins are registered so the vector for idx is stable for the
  // whole RUN cycle in which its output is compared; the next vector is fetched
  // from vec_data (which already addresses idx+1) at the end of that cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vec_addr       <= '0;
      dut_reset      <= 1'b1;
      dut_in         <= 1'b0;
      expected       <= 1'b0;
      idx            <= '0;
      aborted        <= 1'b0;
      error_count    <= '0;
      err_seen       <= 1'b0;
      first_err_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          dut_reset <= 1'b1;
          dut_in    <= 1'b0;
          if (start) begin
            error_count <= '0;
            err_seen    <= 1'b0;
            aborted     <= 1'b0;
            vec_addr    <= '0;
          end
        end
        ST_LOAD: begin
          if (stop) begin
            aborted   <= 1'b1;
            dut_reset <= 1'b1;
            dut_in    <= 1'b0;
          end else begin
            dut_reset <= vec_data[VEC_RST];
            dut_in    <= vec_data[VEC_IN];
            expected  <= vec_data[VEC_EXP];
            idx       <= '0;
            if (!addr_at_end) vec_addr <= vec_addr + AW'(1);
          end
        end
        ST_RUN: begin
          // The compare of this cycle counts even when stop ends the run here.
          if (mismatch) begin
            error_count <= error_count + CW'(1);
            if (!err_seen) begin
              err_seen       <= 1'b1;
              first_err_addr <= idx;
            end
          end
          if (stop || is_last) begin
            if (stop) aborted <= 1'b1;
            dut_reset <= 1'b1;
            dut_in    <= 1'b0;
          end else begin
            dut_reset <= vec_data[VEC_RST];
            dut_in    <= vec_data[VEC_IN];
            expected  <= vec_data[VEC_EXP];
            idx       <= idx + AW'(1);
            if (!addr_at_end) vec_addr <= vec_addr + AW'(1);
          end
        end
        ST_DONE: begin
          dut_reset <= 1'b1;
          dut_in    <= 1'b0;
        end
        default: begin
          dut_reset <= 1'b1;
          dut_in    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_vector_sequencer.sv
// Testbench for fsm_vector_sequencer: a 13-deep instance driving a "101" Mealy
// detector, plus a 1-deep instance with a fixed vector and a stuck-high output.
module tb_fsm_vector_sequencer;

  localparam int DEPTH = 13;
  localparam int AW    = 5;
  localparam int CW    = 4;
  localparam int MAXC  = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, stop;

  logic [AW-1:0] vec_addr, first_err_addr;
  logic [2:0]    vec_data;
  logic          dut_reset, dut_in, dut_out, busy, done, aborted, mismatch, err_seen;
  logic [CW-1:0] error_count;

  logic [0:0] a1_vec_addr, a1_first;
  logic       a1_dut_reset, a1_dut_in, a1_busy, a1_done, a1_aborted, a1_mismatch, a1_seen;
  logic [0:0] a1_count;

  logic [DEPTH-1:0] tab_rst, tab_in, tab_exp;
  // Input pattern, bit i = vector i
  localparam logic [DEPTH-1:0] IN_PATTERN = 13'b1100101101010;

  fsm_vector_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .vec_addr(vec_addr), .vec_data(vec_data),
    .dut_reset(dut_reset), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .aborted(aborted), .mismatch(mismatch),
    .error_count(error_count), .err_seen(err_seen), .first_err_addr(first_err_addr)
  );

  fsm_vector_sequencer #(.DEPTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .vec_addr(a1_vec_addr), .vec_data(3'b010),
    .dut_reset(a1_dut_reset), .dut_in(a1_dut_in), .dut_out(1'b1),
    .busy(a1_busy), .done(a1_done), .aborted(a1_aborted), .mismatch(a1_mismatch),
    .error_count(a1_count), .err_seen(a1_seen), .first_err_addr(a1_first)
  );

  // Combinational vector ROM
  always_comb begin
    vec_data = 3'b000;
    if (int'(vec_addr) < DEPTH)
      vec_data = {tab_rst[int'(vec_addr)], tab_in[int'(vec_addr)], tab_exp[int'(vec_addr)]};
  end

  // FSM under test: overlapping "101" Mealy detector
  logic [1:0] fsm_s;
  always_ff @(posedge clk) begin
    if (dut_reset) fsm_s <= 2'd0;
    else begin
      case (fsm_s)
        2'd0:    fsm_s <= dut_in ? 2'd1 : 2'd0;
        2'd1:    fsm_s <= dut_in ? 2'd1 : 2'd2;
        default: fsm_s <= dut_in ? 2'd1 : 2'd0;
      endcase
    end
  end
  assign dut_out = !dut_reset && (fsm_s == 2'd2) && dut_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-cycle observations, index = cycles since the start cycle
  logic          obs_busy [MAXC], obs_done [MAXC], obs_in [MAXC], obs_rst [MAXC];
  logic          obs_mm [MAXC], obs_seen [MAXC], obs_abort [MAXC];
  logic [AW-1:0] obs_addr [MAXC], obs_first [MAXC];
  logic [CW-1:0] obs_cnt [MAXC];
  logic          a1_done_o [MAXC], a1_mm_o [MAXC], a1_busy_o [MAXC];
  int            last_ncyc;

  typedef struct {
    int            k;
    logic          rst;
    logic          in_bit;
    logic [AW-1:0] addr;
    logic          mm;
  } exp_t;
  exp_t sb_q[$];

  // Reference behaviour of the detector over a vector table
  function automatic logic [DEPTH-1:0] golden_outs(input logic [DEPTH-1:0] r, input logic [DEPTH-1:0] d);
    int s = 0;
    logic [DEPTH-1:0] g = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r[i]) begin
        g[i] = 1'b0;
        s = 0;
      end else begin
        g[i] = (s == 2) && d[i];
        if (d[i]) s = 1;
        else      s = (s == 1) ? 2 : 0;
      end
    end
    return g;
  endfunction

  task automatic set_table(input logic [DEPTH-1:0] flip);
    tab_rst = 13'b1;
    tab_in  = IN_PATTERN;
    tab_exp = golden_outs(13'b1, IN_PATTERN) ^ flip;
  endtask

  // Expected pin/compare values for RUN vectors 0..last_idx
  task automatic push_run(input int last_idx);
    logic [DEPTH-1:0] g;
    exp_t e;
    g = golden_outs(tab_rst, tab_in);
    for (int i = 0; i <= last_idx; i++) begin
      e.k      = i + 2;
      e.rst    = tab_rst[i];
      e.in_bit = tab_in[i];
      e.addr   = AW'((i + 1 > DEPTH - 1) ? DEPTH - 1 : i + 1);
      e.mm     = g[i] ^ tab_exp[i];
      sb_q.push_back(e);
    end
  endtask

  // Starts a run at k=0 and records outputs each cycle; stop/reset/extra starts are
  // asserted during the RUN cycle of the given vector index (-1 = never).
  task automatic run_vectors(input int stop_at, input int reset_at,
                             input int pulse_a, input int pulse_b, input int ncyc);
    last_ncyc = ncyc;
    for (int k = 0; k < ncyc; k++) begin
      obs_busy[k] = busy;   obs_done[k] = done;   obs_in[k] = dut_in;
      obs_rst[k] = dut_reset; obs_mm[k] = mismatch; obs_addr[k] = vec_addr;
      obs_cnt[k] = error_count; obs_seen[k] = err_seen; obs_first[k] = first_err_addr;
      obs_abort[k] = aborted;
      a1_done_o[k] = a1_done; a1_mm_o[k] = a1_mismatch; a1_busy_o[k] = a1_busy;
      start = (k == 0) || (pulse_a >= 0 && k == pulse_a + 2) || (pulse_b >= 0 && k == pulse_b + 2);
      stop  = (stop_at >= 0 && k == stop_at + 2);
      reset = !(reset_at >= 0 && k == reset_at + 2);
      @(negedge clk);
    end
    start = 1'b0;
    stop  = 1'b0;
    reset = 1'b1;
  endtask

  function automatic int first_done();
    for (int k = 0; k < last_ncyc; k++) if (obs_done[k]) return k;
    return -1;
  endfunction

  function automatic int done_count();
    int c = 0;
    for (int k = 0; k < last_ncyc; k++) if (obs_done[k]) c++;
    return c;
  endfunction

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; stop = 1'b0;
    set_table('0);
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset done: got %b expected 0", done); end
    n_checks++; if (dut_reset !== 1'b1) begin n_fail++; $display("[TB] FAIL reset dut_reset: got %b expected 1", dut_reset); end
    n_checks++; if (dut_in !== 1'b0) begin n_fail++; $display("[TB] FAIL reset dut_in: got %b expected 0", dut_in); end
    n_checks++; if (vec_addr !== '0) begin n_fail++; $display("[TB] FAIL reset vec_addr: got %0d expected 0", vec_addr); end
    n_checks++; if ({aborted, err_seen, mismatch} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset flags: got %b expected 000", {aborted, err_seen, mismatch}); end
    n_checks++; if ({error_count, first_err_addr} !== '0) begin n_fail++; $display("[TB] FAIL reset counters: got %0d/%0d expected 0/0", error_count, first_err_addr); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_all_match();
    exp_t e;
    set_table('0);
    push_run(DEPTH - 1);
    run_vectors(-1, -1, -1, -1, 20);
    n_checks++; if (obs_busy[1] !== 1'b1) begin n_fail++; $display("[TB] FAIL all_match load busy: got %b expected 1", obs_busy[1]); end
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if ({obs_rst[e.k], obs_in[e.k], obs_addr[e.k], obs_mm[e.k]} !== {e.rst, e.in_bit, e.addr, e.mm}) begin
        n_fail++;
        $display("[TB] FAIL all_match vec %0d {rst,in,addr,mm}: got %b expected %b", e.k - 2,
                 {obs_rst[e.k], obs_in[e.k], obs_addr[e.k], obs_mm[e.k]}, {e.rst, e.in_bit, e.addr, e.mm});
      end
    end
    n_checks++; if (first_done() !== 15) begin n_fail++; $display("[TB] FAIL all_match done cycle: got %0d expected 15", first_done()); end
    n_checks++; if (done_count() !== 1) begin n_fail++; $display("[TB] FAIL all_match done pulses: got %0d expected 1", done_count()); end
    n_checks++; if ({error_count, err_seen, aborted} !== {4'd0, 1'b0, 1'b0}) begin n_fail++; $display("[TB] FAIL all_match result {cnt,seen,abort}: got %b expected 000000", {error_count, err_seen, aborted}); end
  endtask

  task automatic test_two_errors();
    exp_t e;
    set_table((13'd1 << 5) | (13'd1 << 9));
    push_run(DEPTH - 1);
    run_vectors(-1, -1, -1, -1, 20);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if ({obs_in[e.k], obs_addr[e.k], obs_mm[e.k]} !== {e.in_bit, e.addr, e.mm}) begin
        n_fail++;
        $display("[TB] FAIL two_errors vec %0d {in,addr,mm}: got %b expected %b", e.k - 2,
                 {obs_in[e.k], obs_addr[e.k], obs_mm[e.k]}, {e.in_bit, e.addr, e.mm});
      end
    end
    n_checks++; if (error_count !== 4'd2) begin n_fail++; $display("[TB] FAIL two_errors error_count: got %0d expected 2", error_count); end
    n_checks++; if (first_err_addr !== 5'd5) begin n_fail++; $display("[TB] FAIL two_errors first_err_addr: got %0d expected 5", first_err_addr); end
    n_checks++; if (err_seen !== 1'b1) begin n_fail++; $display("[TB] FAIL two_errors err_seen: got %b expected 1", err_seen); end
  endtask

  task automatic test_stop();
    exp_t e;
    set_table(13'd1 << 4);
    push_run(4);
    run_vectors(4, -1, -1, -1, 12);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if ({obs_in[e.k], obs_mm[e.k]} !== {e.in_bit, e.mm}) begin
        n_fail++;
        $display("[TB] FAIL stop vec %0d {in,mm}: got %b expected %b", e.k - 2, {obs_in[e.k], obs_mm[e.k]}, {e.in_bit, e.mm});
      end
    end
    n_checks++; if (first_done() !== 7) begin n_fail++; $display("[TB] FAIL stop done cycle: got %0d expected 7", first_done()); end
    n_checks++; if ({obs_abort[7], obs_rst[7], obs_busy[7]} !== 3'b110) begin n_fail++; $display("[TB] FAIL stop done-cycle {aborted,dut_reset,busy}: got %b expected 110", {obs_abort[7], obs_rst[7], obs_busy[7]}); end
    n_checks++; if (error_count !== 4'd1) begin n_fail++; $display("[TB] FAIL stop error_count: got %0d expected 1", error_count); end
    n_checks++; if (aborted !== 1'b1) begin n_fail++; $display("[TB] FAIL stop aborted held: got %b expected 1", aborted); end
  endtask

  task automatic test_reset_mid_run();
    set_table(13'd1 << 3);
    run_vectors(-1, 7, -1, -1, 14);
    n_checks++; if (obs_cnt[9] !== 4'd1) begin n_fail++; $display("[TB] FAIL mid_reset count before reset: got %0d expected 1", obs_cnt[9]); end
    n_checks++;
    if ({obs_busy[10], obs_rst[10], obs_in[10], obs_addr[10], obs_cnt[10], obs_seen[10], obs_first[10], obs_abort[10], obs_mm[10]}
        !== {1'b0, 1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL mid_reset state after reset: got %b expected %b",
               {obs_busy[10], obs_rst[10], obs_in[10], obs_addr[10], obs_cnt[10], obs_seen[10], obs_first[10], obs_abort[10], obs_mm[10]},
               {1'b0, 1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0});
    end
    n_checks++; if (first_done() !== -1) begin n_fail++; $display("[TB] FAIL mid_reset done pulse: got cycle %0d expected none", first_done()); end
    set_table('0);
    run_vectors(-1, -1, -1, -1, 20);
    n_checks++; if (first_done() !== 15) begin n_fail++; $display("[TB] FAIL mid_reset rerun done cycle: got %0d expected 15", first_done()); end
    n_checks++; if (error_count !== 4'd0) begin n_fail++; $display("[TB] FAIL mid_reset rerun error_count: got %0d expected 0", error_count); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    set_table('0);
    push_run(DEPTH - 1);
    run_vectors(-1, -1, 2, 6, 20);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if ({obs_busy[e.k], obs_addr[e.k], obs_in[e.k]} !== {1'b1, e.addr, e.in_bit}) begin
        n_fail++;
        $display("[TB] FAIL back_to_back vec %0d {busy,addr,in}: got %b expected %b", e.k - 2,
                 {obs_busy[e.k], obs_addr[e.k], obs_in[e.k]}, {1'b1, e.addr, e.in_bit});
      end
    end
    n_checks++; if (done_count() !== 1) begin n_fail++; $display("[TB] FAIL back_to_back done pulses: got %0d expected 1", done_count()); end
    n_checks++; if (first_done() !== 15) begin n_fail++; $display("[TB] FAIL back_to_back done cycle: got %0d expected 15", first_done()); end
  endtask

  task automatic test_depth_one();
    run_vectors(-1, -1, -1, -1, 8);
    n_checks++; if ({a1_busy_o[1], a1_busy_o[2], a1_busy_o[3]} !== 3'b110) begin n_fail++; $display("[TB] FAIL depth1 busy k1..3: got %b expected 110", {a1_busy_o[1], a1_busy_o[2], a1_busy_o[3]}); end
    n_checks++; if (a1_mm_o[2] !== 1'b1) begin n_fail++; $display("[TB] FAIL depth1 mismatch: got %b expected 1", a1_mm_o[2]); end
    n_checks++; if ({a1_done_o[2], a1_done_o[3], a1_done_o[4]} !== 3'b010) begin n_fail++; $display("[TB] FAIL depth1 done k2..4: got %b expected 010", {a1_done_o[2], a1_done_o[3], a1_done_o[4]}); end
    n_checks++; if ({a1_count, a1_seen, a1_first, a1_vec_addr} !== 4'b1100) begin n_fail++; $display("[TB] FAIL depth1 {cnt,seen,first,addr}: got %b expected 1100", {a1_count, a1_seen, a1_first, a1_vec_addr}); end
  endtask

  initial begin
    test_reset();
    test_all_match();
    test_two_errors();
    test_stop();
    test_reset_mid_run();
    test_back_to_back();
    test_depth_one();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
